// File: rtl/hole_scan_ctrl.sv
// Hole-table scanner: on a frame tick, snapshots the ball and walks the hole table
// one entry per cycle, stopping at the first hole within RADIUS of the ball centre.
module hole_scan_ctrl #(
    parameter int NUM_HOLES = 8,
    parameter int IDX_W     = 3,
    parameter int RADIUS    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             is_game_playing,
    input  logic [9:0]       i_bl_x,
    input  logic [9:0]       i_bl_y,
    output logic [IDX_W-1:0] o_hole_addr,
    input  logic [9:0]       i_hole_pos_x,
    input  logic [9:0]       i_hole_pos_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fall_in,
    output logic [IDX_W-1:0] o_hole_idx
);

    localparam logic [20:0]      R2   = 21'(RADIUS * RADIUS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_HOLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HALT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             issue_q, issue_d;
    logic             tag_vld_q, tag_vld_d;
    logic [IDX_W-1:0] tag_idx_q, tag_idx_d;
    logic [9:0]       bx_q, bx_d, by_q, by_d;
    logic             done_q, done_d;
    logic             fall_q, fall_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [20:0]      d2;
    logic             hit;

    // Widen to 11-bit signed before subtracting so a far-apart pair never wraps.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return diff[10] ? 10'(-diff) : diff[9:0];
    endfunction

    function automatic logic [20:0] sq(input logic [9:0] v);
        return 21'(v) * 21'(v);
    endfunction

    always_comb begin
        d2  = sq(abs_diff(bx_q, i_hole_pos_x)) + sq(abs_diff(by_q, i_hole_pos_y));
        hit = (d2 <= R2);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        issue_d   = issue_q;
        tag_vld_d = 1'b0;
        tag_idx_d = tag_idx_q;
        bx_d      = bx_q;
        by_d      = by_q;
        done_d    = 1'b0;
        fall_d    = fall_q;
        idx_d     = idx_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && is_game_playing && !fall_q) begin
                    state_d = S_SCAN;
                    bx_d    = i_bl_x;
                    by_d    = i_bl_y;
                    addr_d  = '0;
                    issue_d = 1'b1;
                end
            end
            S_SCAN: begin
                if (!is_game_playing) begin
                    state_d = S_IDLE;
                    issue_d = 1'b0;
                end else begin
                    if (issue_q) begin
                        tag_vld_d = 1'b1;
                        tag_idx_d = addr_q;
                        if (addr_q == LAST) issue_d = 1'b0;
                        else                addr_d  = addr_q + IDX_W'(1);
                    end
                    // A hit squashes the entry already in flight behind it.
                    if (tag_vld_q && hit) begin
                        state_d   = S_HALT;
                        fall_d    = 1'b1;
                        idx_d     = tag_idx_q;
                        done_d    = 1'b1;
                        tag_vld_d = 1'b0;
                        issue_d   = 1'b0;
                    end else if (tag_vld_q && tag_idx_q == LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_HALT:  ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            issue_q   <= 1'b0;
            tag_vld_q <= 1'b0;
            tag_idx_q <= '0;
            done_q    <= 1'b0;
            fall_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            issue_q   <= issue_d;
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
            done_q    <= done_d;
            fall_q    <= fall_d;
            idx_q     <= idx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        bx_q <= bx_d;
        by_q <= by_d;
    end

    assign o_hole_addr = addr_q;
    assign o_busy      = (state_q == S_SCAN);
    assign o_done      = done_q;
    assign o_fall_in   = fall_q;
    assign o_hole_idx  = idx_q;

endmodule

// File: tb/tb_hole_scan_ctrl.sv
// Bench for hole_scan_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_hole_scan_ctrl;

    localparam int N = 8;
    localparam int R = 16;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_start = 1'b0;
    logic       is_game_playing = 1'b1;
    logic [9:0] i_bl_x = '0, i_bl_y = '0;
    logic [2:0] o_hole_addr;
    logic [9:0] i_hole_pos_x, i_hole_pos_y;
    logic       o_busy, o_done, o_fall_in;
    logic [2:0] o_hole_idx;

    hole_scan_ctrl #(.NUM_HOLES(N), .IDX_W(3), .RADIUS(R)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .is_game_playing(is_game_playing),
        .i_bl_x(i_bl_x), .i_bl_y(i_bl_y), .o_hole_addr(o_hole_addr),
        .i_hole_pos_x(i_hole_pos_x), .i_hole_pos_y(i_hole_pos_y),
        .o_busy(o_busy), .o_done(o_done), .o_fall_in(o_fall_in), .o_hole_idx(o_hole_idx)
    );

    always #5 i_clk = ~i_clk;

    // Hole table: one-cycle registered read, as the ROM behaves.
    logic [9:0] hx [N];
    logic [9:0] hy [N];
    always @(posedge i_clk) begin
        i_hole_pos_x <= hx[o_hole_addr];
        i_hole_pos_y <= hy[o_hole_addr];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int first_hit(input int bx, input int by);
        for (int k = 0; k < N; k++) begin
            int dx, dy;
            dx = bx - int'(hx[k]);
            dy = by - int'(hy[k]);
            if (dx * dx + dy * dy <= R * R) return k;
        end
        return -1;
    endfunction

    // Behavioural model: on an accepted start, the outcome and the cycle it lands
    // are decided up front from the snapshot; later edges just count down.
    bit m_scan = 0, m_halt = 0;
    int m_cnt = 0, m_el = 0, m_k = -1;
    bit exp_busy = 0, exp_done = 0, exp_fall = 0, exp_addr_v = 0;
    int exp_idx = 0, exp_addr = 0;

    always @(posedge i_clk) begin
        exp_done = 0;
        if (i_rst) begin
            m_scan = 0; m_halt = 0;
            exp_busy = 0; exp_fall = 0; exp_idx = 0;
            exp_addr_v = 1; exp_addr = 0;
        end else if (m_scan) begin
            if (!is_game_playing) begin
                m_scan = 0; exp_busy = 0; exp_addr_v = 0;
            end else begin
                m_el++; m_cnt--;
                exp_addr_v = (m_el <= N);
                exp_addr = m_el - 1;
                if (m_cnt == 0) begin
                    m_scan = 0; exp_busy = 0; exp_done = 1; exp_addr_v = 0;
                    if (m_k >= 0) begin
                        m_halt = 1; exp_fall = 1; exp_idx = m_k;
                    end
                end
            end
        end else if (!m_halt) begin
            if (i_start && is_game_playing) begin
                m_scan = 1; exp_busy = 1;
                m_k = first_hit(int'(i_bl_x), int'(i_bl_y));
                m_cnt = (m_k >= 0) ? 2 + m_k : 1 + N;
                m_el = 1; exp_addr_v = 1; exp_addr = 0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("busy", int'(o_busy), int'(exp_busy));
            check("done", int'(o_done), int'(exp_done));
            check("fall_in", int'(o_fall_in), int'(exp_fall));
            if (exp_fall) check("hole_idx", int'(o_hole_idx), exp_idx);
            if (exp_addr_v) check("hole_addr", int'(o_hole_addr), exp_addr);
        end
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1;
        @(negedge i_clk);
        i_rst = 0;
    endtask

    task automatic set_far();
        for (int k = 0; k < N; k++) begin
            hx[k] = 10'(300 + k * 50);
            hy[k] = 10'd700;
        end
    endtask

    task automatic set_ball(input int x, input int y);
        i_bl_x = 10'(x);
        i_bl_y = 10'(y);
    endtask

    // Pulse start; report cycles from start to o_done (-1 on timeout) and busy cycles.
    task automatic do_start(input int mv_x, input int mv_y, output int lat, output int nbusy);
        int t0;
        @(negedge i_clk);
        i_start = 1;
        t0 = cyc;
        lat = -1;
        nbusy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            i_start = 0;
            if (mv_x >= 0 && i < 6) set_ball(mv_x, mv_y);
            if (o_busy) nbusy++;
            if (o_done) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, t0, nd;
        set_far();
        set_ball(100, 100);
        do_reset();
        chk_en = 1;
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_fall", int'(o_fall_in), 0);
        check("rst_idx", int'(o_hole_idx), 0);
        check("rst_addr", int'(o_hole_addr), 0);

        // Full miss.
        do_start(-1, 0, lat, nb);
        check("miss_lat", lat, 10);
        check("miss_busy_cycles", nb, 9);
        check("miss_fall", int'(o_fall_in), 0);

        // dx=16, dy=0 is exactly on the radius.
        do_reset(); set_far(); hx[4] = 10'd116; hy[4] = 10'd100; set_ball(100, 100);
        do_start(-1, 0, lat, nb);
        check("edge16_lat", lat, 7);
        check("edge16_idx", int'(o_hole_idx), 4);

        // dx=12, dy=12 gives 288, just outside.
        do_reset(); set_far(); hx[4] = 10'd112; hy[4] = 10'd112;
        do_start(-1, 0, lat, nb);
        check("diag12_lat", lat, 10);
        check("diag12_fall", int'(o_fall_in), 0);

        // Far corners must not wrap into a hit.
        set_far(); hx[4] = 10'd1020; hy[4] = 10'd100; set_ball(5, 100);
        do_start(-1, 0, lat, nb);
        check("wrap_lat", lat, 10);
        check("wrap_fall", int'(o_fall_in), 0);

        // Overlap: lowest index wins.
        set_far(); hx[2] = 10'd105; hy[2] = 10'd100; hx[5] = 10'd100; hy[5] = 10'd100;
        set_ball(100, 100);
        do_start(-1, 0, lat, nb);
        check("overlap_lat", lat, 5);
        check("overlap_idx", int'(o_hole_idx), 2);

        // Exact hit, then further starts are ignored.
        do_reset(); set_far(); hx[3] = 10'd320; hy[3] = 10'd240; set_ball(320, 240);
        do_start(-1, 0, lat, nb);
        check("exact_lat", lat, 6);
        check("exact_idx", int'(o_hole_idx), 3);
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            i_start = (i % 3 == 0);
        end
        i_start = 0;
        @(negedge i_clk);
        check("halt_fall", int'(o_fall_in), 1);
        check("halt_idx", int'(o_hole_idx), 3);
        check("halt_busy", int'(o_busy), 0);

        // Abort: game stops in cycle T+4.
        do_reset(); set_far(); set_ball(100, 100);
        @(negedge i_clk);
        i_start = 1; t0 = cyc;
        while (cyc < t0 + 4) begin @(negedge i_clk); i_start = 0; end
        is_game_playing = 0;
        @(negedge i_clk);
        check("abort_busy", int'(o_busy), 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            if (o_done) nd++;
        end
        check("abort_no_done", nd, 0);
        is_game_playing = 1;

        // Reset in the middle of a scan that would have hit.
        set_far(); hx[3] = 10'd320; hy[3] = 10'd240; set_ball(320, 240);
        @(negedge i_clk);
        i_start = 1; t0 = cyc;
        while (cyc < t0 + 3) begin @(negedge i_clk); i_start = 0; end
        i_rst = 1;
        @(negedge i_clk);
        i_rst = 0;
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_fall", int'(o_fall_in), 0);
        check("midrst_addr", int'(o_hole_addr), 0);
        repeat (8) @(negedge i_clk);
        check("midrst_stay", int'(o_fall_in), 0);

        // Ball moves into hole 6 after the snapshot.
        set_far(); hx[6] = 10'd500; hy[6] = 10'd400; set_ball(100, 100);
        do_start(500, 400, lat, nb);
        check("snap_lat", lat, 10);
        check("snap_fall", int'(o_fall_in), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            @(negedge i_clk);
            i_rst = 0;
            if (m_halt && $urandom % 25 == 0) begin
                i_rst = 1;
            end else if (!m_scan && $urandom % 12 == 0) begin
                for (int k = 0; k < N; k++) begin
                    hx[k] = 10'($urandom % 1024);
                    hy[k] = 10'($urandom % 1024);
                end
                if ($urandom % 3 != 0) begin
                    int j, vx, vy;
                    j = int'($urandom % N);
                    vx = int'(hx[j]) + int'($urandom_range(36)) - 18;
                    vy = int'(hy[j]) + int'($urandom_range(36)) - 18;
                    vx = (vx < 0) ? 0 : (vx > 1023) ? 1023 : vx;
                    vy = (vy < 0) ? 0 : (vy > 1023) ? 1023 : vy;
                    set_ball(vx, vy);
                    if ($urandom % 3 == 0) begin
                        j = int'($urandom % N);
                        hx[j] = 10'(vx);
                        hy[j] = 10'(vy);
                    end
                end else begin
                    set_ball(int'($urandom % 1024), int'($urandom % 1024));
                end
            end else if ($urandom % 6 == 0) begin
                set_ball(int'($urandom % 1024), int'($urandom % 1024));
            end
            i_start = ($urandom % 4 == 0);
            is_game_playing = ($urandom % 40 != 0);
        end
        @(negedge i_clk);
        i_start = 0;
        i_rst = 0;
        repeat (3) @(negedge i_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
